// File: rtl/ariane_pkg.sv
// Trimmed local ariane_pkg: the frontend fetch entry type and the default
// requester count shared by the decode-stage fetch arbiter.
package ariane_pkg;

    localparam int ID_ARB_NR_REQ = 2;

    typedef struct packed {
        logic [63:0] address;
        logic [31:0] instruction;
        logic        page_fault;
    } frontend_fetch_t;

endpackage

// File: rtl/id_fetch_arbiter_pkg.sv
// Shared types and constants for the decode-stage fetch arbiter.
package id_fetch_arbiter_pkg;

    // HOLD means the output register carries an entry not yet taken by decode
    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_e;

    localparam int BURST_W = 4;

endpackage

// File: rtl/id_arb_prio_sel.sv
// Combinational lowest-index-first selector over (valid & ~mask).
module id_arb_prio_sel #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     valid,
    input  logic [N-1:0]     mask,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (valid[i] && !mask[i] && !any) begin
                grant[i] = 1'b1;
                idx      = IDX_W'(i);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/id_fetch_arbiter.sv
// Fixed-priority arbiter feeding one buffered fetch entry to decode.
// Define ID_ARB_BURST_LIMIT_EN to add the MAX_BURST consecutive-grant guard.
module id_fetch_arbiter
    import ariane_pkg::*;
    import id_fetch_arbiter_pkg::*;
#(
    parameter  int NR_REQ    = ID_ARB_NR_REQ,
    parameter  int MAX_BURST = 4,
    localparam int IDX_W     = (NR_REQ > 1) ? $clog2(NR_REQ) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic [NR_REQ-1:0]            req_valid_i,
    input  frontend_fetch_t [NR_REQ-1:0] req_entry_i,
    output logic [NR_REQ-1:0]            req_ack_o,
    output frontend_fetch_t              fetch_entry_o,
    output logic                         fetch_entry_valid_o,
    input  logic                         fetch_ack_i,
    output logic [IDX_W-1:0]             grant_idx_o,
    output logic                         busy_o
);

    if (NR_REQ < 2 || NR_REQ > 8 || MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_param
        $error("id_fetch_arbiter: NR_REQ must be 2..8 and MAX_BURST 1..15");
    end

    arb_state_e      state_q;
    frontend_fetch_t entry_q;
    logic [IDX_W-1:0] idx_q;

    logic              slot_free;
    logic              grant_en;
    logic              win;
    logic [NR_REQ-1:0] mask;
    logic [NR_REQ-1:0] sel_grant;
    logic [IDX_W-1:0]  sel_idx;
    logic              sel_any;

    // Decode taking the held entry frees the slot in the same cycle
    assign slot_free = (state_q == ARB_IDLE) || fetch_ack_i;
    assign grant_en  = slot_free && !flush_i && !rst_i;
    assign win       = grant_en && sel_any;
    assign req_ack_o = win ? sel_grant : '0;

`ifdef ID_ARB_BURST_LIMIT_EN
    logic [BURST_W-1:0] burst_cnt_q;
    logic [IDX_W-1:0]   last_idx_q;
    logic [NR_REQ-1:0]  last_oh;

    always_comb begin
        last_oh = '0;
        for (int i = 0; i < NR_REQ; i++) begin
            last_oh[i] = (last_idx_q == IDX_W'(i));
        end
    end

    // A saturated streak yields to any competitor, but never starves a lone requester
    assign mask = ((burst_cnt_q == BURST_W'(MAX_BURST)) && |(req_valid_i & ~last_oh))
                  ? last_oh : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            burst_cnt_q <= '0;
            last_idx_q  <= '0;
        end else if (flush_i) begin
            burst_cnt_q <= '0;
        end else if (win) begin
            if (sel_idx == last_idx_q) begin
                if (burst_cnt_q != BURST_W'(MAX_BURST)) begin
                    burst_cnt_q <= burst_cnt_q + 1'b1;
                end
            end else begin
                burst_cnt_q <= BURST_W'(1);
                last_idx_q  <= sel_idx;
            end
        end
    end
`else
    assign mask = '0;
`endif

    id_arb_prio_sel #(
        .N     (NR_REQ),
        .IDX_W (IDX_W)
    ) u_prio_sel (
        .valid (req_valid_i),
        .mask  (mask),
        .grant (sel_grant),
        .idx   (sel_idx),
        .any   (sel_any)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ARB_IDLE;
            entry_q <= '0;
            idx_q   <= '0;
        end else if (flush_i) begin
            state_q <= ARB_IDLE;
        end else if (win) begin
            state_q <= ARB_HOLD;
            entry_q <= req_entry_i[sel_idx];
            idx_q   <= sel_idx;
        end else if (slot_free) begin
            state_q <= ARB_IDLE;
        end
    end

    assign fetch_entry_o       = entry_q;
    assign fetch_entry_valid_o = (state_q == ARB_HOLD);
    assign busy_o              = (state_q == ARB_HOLD);
    assign grant_idx_o         = idx_q;

endmodule
